sii_ncu_arb: RTL and testbench
==============================

SII_NCU_ARB -- requirements
Module: sii_ncu_arb

Interface
REQ-001 SHALL have parameter NUM_BEATS, default 4, meaning 32-bit beats per transfer; header carried in beat 0.
REQ-002 SHALL have port iol2clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_l  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mondo_vld  in  1  requester 0 (Mondo interrupt) has a transfer pending.
REQ-005 SHALL have port mondo_data  in  32*NUM_BEATS  requester 0 payload; beat k = bits [32k+31:32k].
REQ-006 SHALL have port mondo_ack  out  1  one-cycle pulse; requester 0 payload captured.
REQ-007 SHALL have port pio_vld  in  1  requester 1 (PIO completion) has a transfer pending.
REQ-008 SHALL have port pio_data  in  32*NUM_BEATS  requester 1 payload, same layout.
REQ-009 SHALL have port pio_ack  out  1  one-cycle pulse; requester 1 payload captured.
REQ-010 SHALL have port sii_ncu_req  out  1  transfer request to NCU.
REQ-011 SHALL have port ncu_sii_gnt  in  1  NCU grant.
REQ-012 SHALL have port sii_ncu_data  out  32  payload beat.
REQ-013 SHALL have port sii_ncu_dparity  out  2  [1] = XOR of data[31:16], [0] = XOR of data[15:0].
REQ-014 SHALL have port err_spurious_gnt  out  1  one-cycle pulse; grant seen while not in REQ.

Function
REQ-015 SHALL implement states IDLE, REQ, XFER; all outputs registered.
REQ-016 SHALL, in IDLE with any vld sampled high, select a winner, capture its payload, and enter REQ; the next cycle shows sii_ncu_req=1 and the winner's ack=1 for exactly one cycle.
REQ-017 SHALL hold sii_ncu_req=1 in REQ until ncu_sii_gnt is sampled high, with no timeout.
REQ-018 SHALL, on grant sampled high in cycle G, drive sii_ncu_req=0 and beat 0 on sii_ncu_data in cycle G+1, then beats 1..NUM_BEATS-1 in cycles G+2..G+NUM_BEATS.
REQ-019 SHALL, in the cycle after the last beat, return sii_ncu_data and sii_ncu_dparity to 0; the earliest next sii_ncu_req is the cycle after that (one idle cycle minimum).
REQ-020 SHALL drive sii_ncu_dparity aligned to the same cycle as its sii_ncu_data beat; 0 when data is idle.
REQ-021 SHALL pass the payload unmodified; header fields in beat 0 [15:0] are the requester's responsibility.
REQ-022 SHALL use a beat counter of width clog2(NUM_BEATS), wrapping to 0 on exit from XFER.
REQ-023 SHALL ignore vld changes outside IDLE; a requester whose vld is still high after its ack is treated as a new transfer.
REQ-024 SHALL, on grant sampled outside REQ, pulse err_spurious_gnt and leave state and data unchanged.
REQ-025 SHALL treat grant held high across REQ exit as one grant only; a grant during XFER sets err_spurious_gnt.

Reset
REQ-026 SHALL, on rst_l low at any time including mid-transfer, immediately force state=IDLE, beat counter=0, priority pointer=requester 0, and all outputs to 0; the aborted transfer is not resumed.
REQ-027 SHALL leave reset with the first arbitration decision in the first edge after rst_l rises.

Configuration
REQ-028 SHALL, with SII_NCU_ARB_RR_EN defined, arbitrate round-robin: the last winner gets lowest priority on simultaneous vld.
REQ-029 SHALL, without SII_NCU_ARB_RR_EN, use fixed priority, mondo over pio; the priority pointer is absent.

Structure
REQ-030 SHALL place the state enum, the beat width (32), and the requester index constants in package sii_ncu_arb_pkg.
REQ-031 SHALL instantiate sub-module sii_ncu_par_gen (32-bit data in, 2-bit parity out) for parity.

Verification
REQ-032 SHALL verify: mondo_vld=1 only, data beats 0x11111111..0x44444444, gnt 3 cycles after req -> mondo_ack pulse, req high 3 cycles, beats in order starting the cycle after gnt, parity 2'b00 each beat.
REQ-033 SHALL verify: both vld=1 simultaneously twice with RR_EN -> mondo then pio; without RR_EN -> mondo both times.
REQ-034 SHALL verify: gnt pulse while IDLE -> err_spurious_gnt=1 for one cycle, sii_ncu_req stays 0.
REQ-035 SHALL verify: rst_l low during beat 2 -> all outputs 0 the same cycle; after release with pio_vld=1, a clean pio transfer follows.
REQ-036 SHALL verify: beat 0 data 0x00010000 -> dparity=2'b10; beat 0 data 0x00000001 -> dparity=2'b01.
REQ-037 SHALL verify: back-to-back pio_vld held high -> second req asserted exactly 2 cycles after the last beat of the first transfer.

Source files
------------

// File: rtl/sii_ncu_arb_pkg.sv
// Shared definitions for the SII-to-NCU arbiter: beat width, requester
// indices and the arbiter state encoding.
package sii_ncu_arb_pkg;

    // Width of one payload beat on the NCU data bus
    localparam int BEAT_W = 32;

    // Requester indices; also the value of the arbitration winner bit
    localparam logic REQ_MONDO = 1'b0;
    localparam logic REQ_PIO   = 1'b1;

    // Arbiter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sii_ncu_par_gen.sv
// Two-bit even-parity generator for one 32-bit data beat:
// parity[1] covers data[31:16], parity[0] covers data[15:0].
module sii_ncu_par_gen
    import sii_ncu_arb_pkg::*;
(
    input  logic [BEAT_W-1:0] data,
    output logic [1:0]        parity
);

    assign parity = {^data[31:16], ^data[15:0]};

endmodule

// File: rtl/sii_ncu_arb.sv
// Arbiter between the Mondo interrupt and PIO completion requesters for the
// single SII-to-NCU transfer path. A winner's payload is captured, the NCU
// is requested, and after the grant the payload is streamed one 32-bit beat
// per cycle with per-halfword parity. All outputs come straight from flops.
//
// Optional build macro: SII_NCU_ARB_RR_EN selects round-robin arbitration
// (last winner loses ties). Without it, Mondo has fixed priority over PIO.
module sii_ncu_arb
    import sii_ncu_arb_pkg::*;
#(
    parameter int NUM_BEATS = 4
) (
    input  logic                        iol2clk,
    input  logic                        rst_l,
    input  logic                        mondo_vld,
    input  logic [BEAT_W*NUM_BEATS-1:0] mondo_data,
    output logic                        mondo_ack,
    input  logic                        pio_vld,
    input  logic [BEAT_W*NUM_BEATS-1:0] pio_data,
    output logic                        pio_ack,
    output logic                        sii_ncu_req,
    input  logic                        ncu_sii_gnt,
    output logic [BEAT_W-1:0]           sii_ncu_data,
    output logic [1:0]                  sii_ncu_dparity,
    output logic                        err_spurious_gnt
);

    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PAY_W = BEAT_W * NUM_BEATS;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [PAY_W-1:0]  payload_q, payload_d;
    logic              req_q, req_d;
    logic [BEAT_W-1:0] data_q, data_d;
    logic [1:0]        par_q, par_d;
    logic              mondo_ack_q, mondo_ack_d;
    logic              pio_ack_q, pio_ack_d;
    logic              err_q, err_d;
    logic              win;

`ifdef SII_NCU_ARB_RR_EN
    logic              prio_q, prio_d;
`endif

    // Parity is computed on the next data value so it lands in the same
    // cycle as the registered beat it describes.
    sii_ncu_par_gen u_par_gen (
        .data   (data_d),
        .parity (par_d)
    );

    // State, counter, captured payload and all registered outputs
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            payload_q   <= '0;
            req_q       <= 1'b0;
            data_q      <= '0;
            par_q       <= 2'b00;
            mondo_ack_q <= 1'b0;
            pio_ack_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef SII_NCU_ARB_RR_EN
            prio_q      <= REQ_MONDO;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            payload_q   <= payload_d;
            req_q       <= req_d;
            data_q      <= data_d;
            par_q       <= par_d;
            mondo_ack_q <= mondo_ack_d;
            pio_ack_q   <= pio_ack_d;
            err_q       <= err_d;
`ifdef SII_NCU_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    // Next-state and next-output logic: arbitrate in IDLE, wait for the
    // grant in REQ, stream beats in XFER; a grant anywhere but REQ is flagged
    // as spurious and otherwise ignored.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 1'b1;
        payload_d   = payload_q;
        req_d       = 1'b0;
        data_d      = '0;
        mondo_ack_d = 1'b0;
        pio_ack_d   = 1'b0;
        err_d       = ncu_sii_gnt && (state_q != REQ);
        win         = REQ_MONDO;
`ifdef SII_NCU_ARB_RR_EN
        prio_d      = prio_q;
`endif

        case (state_q)
            IDLE: begin
                if (mondo_vld || pio_vld) begin
`ifdef SII_NCU_ARB_RR_EN
                    win    = (mondo_vld && pio_vld) ? prio_q : pio_vld;
                    prio_d = ~win;
`else
                    win    = mondo_vld ? REQ_MONDO : REQ_PIO;
`endif
                    payload_d   = (win == REQ_PIO) ? pio_data : mondo_data;
                    mondo_ack_d = (win == REQ_MONDO);
                    pio_ack_d   = (win == REQ_PIO);
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (ncu_sii_gnt) begin
                    cnt_d   = '0;
                    data_d  = payload_q[BEAT_W-1:0];
                    state_d = XFER;
                end else begin
                    req_d = 1'b1;
                end
            end
            XFER: begin
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_inc;
                    data_d = payload_q[BEAT_W*int'(cnt_inc) +: BEAT_W];
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign sii_ncu_req      = req_q;
    assign sii_ncu_data     = data_q;
    assign sii_ncu_dparity  = par_q;
    assign mondo_ack        = mondo_ack_q;
    assign pio_ack          = pio_ack_q;
    assign err_spurious_gnt = err_q;

endmodule

// File: tb/tb_sii_ncu_arb.sv
// Self-checking bench for sii_ncu_arb. Directed scenarios plus a randomized
// loop; expected behaviour comes from a transaction-level model (winner
// choice, captured payload, beat order, parity by popcount).
// Honors SII_NCU_ARB_RR_EN to select the arbitration model.
module tb_sii_ncu_arb;

    localparam int NB = 4;

    logic              iol2clk = 1'b0;
    logic              rst_l;
    logic              mondo_vld;
    logic [32*NB-1:0]  mondo_data;
    logic              mondo_ack;
    logic              pio_vld;
    logic [32*NB-1:0]  pio_data;
    logic              pio_ack;
    logic              sii_ncu_req;
    logic              ncu_sii_gnt;
    logic [31:0]       sii_ncu_data;
    logic [1:0]        sii_ncu_dparity;
    logic              err_spurious_gnt;

    int checks = 0;
    int errors = 0;

`ifdef SII_NCU_ARB_RR_EN
    // Requester that currently wins a tie (0 = mondo, 1 = pio)
    int tieOwner = 0;
`endif

    sii_ncu_arb #(.NUM_BEATS(NB)) dut (
        .iol2clk          (iol2clk),
        .rst_l            (rst_l),
        .mondo_vld        (mondo_vld),
        .mondo_data       (mondo_data),
        .mondo_ack        (mondo_ack),
        .pio_vld          (pio_vld),
        .pio_data         (pio_data),
        .pio_ack          (pio_ack),
        .sii_ncu_req      (sii_ncu_req),
        .ncu_sii_gnt      (ncu_sii_gnt),
        .sii_ncu_data     (sii_ncu_data),
        .sii_ncu_dparity  (sii_ncu_dparity),
        .err_spurious_gnt (err_spurious_gnt)
    );

    // Free-running clock
    always #5 iol2clk = ~iol2clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Parity reference: each bit is set when its halfword has an odd number of ones
    function automatic logic [31:0] expParity(input logic [31:0] w);
        logic hi, lo;
        hi = ($countones(w[31:16]) % 2) == 1;
        lo = ($countones(w[15:0]) % 2) == 1;
        return {30'd0, hi, lo};
    endfunction

    // Arbitration reference: returns winner index and updates tie ownership
    function automatic int predictWinner(input bit mv, input bit pv);
        int w;
`ifdef SII_NCU_ARB_RR_EN
        if (mv && pv) w = tieOwner;
        else          w = mv ? 0 : 1;
        tieOwner = 1 - w;
`else
        w = mv ? 0 : 1;
`endif
        return w;
    endfunction

    task automatic step;
        @(negedge iol2clk);
    endtask

    task automatic randomizeData;
        for (int k = 0; k < NB; k++) begin
            mondo_data[32*k +: 32] = $urandom();
            pio_data[32*k +: 32]   = $urandom();
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req"},   32'(sii_ncu_req), 32'd0);
        checkOutput({tag, "_data"},  sii_ncu_data, 32'd0);
        checkOutput({tag, "_par"},   32'(sii_ncu_dparity), 32'd0);
        checkOutput({tag, "_mack"},  32'(mondo_ack), 32'd0);
        checkOutput({tag, "_pack"},  32'(pio_ack), 32'd0);
    endtask

    // One full transfer: raise vld, check ack/req, grant after reqCycles
    // cycles of req, check every beat, then the idle cycle. Optionally keep
    // vld high, hold the grant one extra cycle, or reset during a beat.
    task automatic applyStimulus(input bit mv, input bit pv, input int reqCycles,
                                 input bit keepVld, input bit holdGnt, input int abortBeat);
        int win;
        logic [32*NB-1:0] expPayload;
        logic [31:0] beat;
        mondo_vld = mv;
        pio_vld   = pv;
        win = predictWinner(mv, pv);
        expPayload = (win == 0) ? mondo_data : pio_data;
        step;
        checkOutput("req_rise",  32'(sii_ncu_req), 32'd1);
        checkOutput("mondo_ack", 32'(mondo_ack), 32'(win == 0));
        checkOutput("pio_ack",   32'(pio_ack), 32'(win == 1));
        checkOutput("req_data",  sii_ncu_data, 32'd0);
        checkOutput("req_err",   32'(err_spurious_gnt), 32'd0);
        if (!keepVld) begin
            mondo_vld = 1'b0;
            pio_vld   = 1'b0;
        end
        randomizeData();
        for (int c = 2; c <= reqCycles; c++) begin
            step;
            checkOutput("req_hold", 32'(sii_ncu_req), 32'd1);
            checkOutput("ack_once", 32'(mondo_ack | pio_ack), 32'd0);
            checkOutput("req_data_idle", sii_ncu_data, 32'd0);
        end
        ncu_sii_gnt = 1'b1;
        for (int b = 0; b < NB; b++) begin
            step;
            beat = expPayload[32*b +: 32];
            checkOutput($sformatf("beat%0d_data", b), sii_ncu_data, beat);
            checkOutput($sformatf("beat%0d_par", b), 32'(sii_ncu_dparity), expParity(beat));
            checkOutput($sformatf("beat%0d_req", b), 32'(sii_ncu_req), 32'd0);
            checkOutput($sformatf("beat%0d_ack", b), 32'(mondo_ack | pio_ack), 32'd0);
            checkOutput($sformatf("beat%0d_err", b), 32'(err_spurious_gnt),
                        32'(holdGnt && b == 1));
            ncu_sii_gnt = holdGnt && (b == 0);
            if (b == abortBeat) begin
                rst_l = 1'b0;
                #1;
                checkIdleOutputs("abort");
                checkOutput("abort_err", 32'(err_spurious_gnt), 32'd0);
`ifdef SII_NCU_ARB_RR_EN
                tieOwner = 0;
`endif
                ncu_sii_gnt = 1'b0;
                return;
            end
        end
        step;
        checkIdleOutputs("post_xfer");
        checkOutput("post_err", 32'(err_spurious_gnt), 32'd0);
    endtask

    initial begin
        rst_l       = 1'b0;
        mondo_vld   = 1'b0;
        pio_vld     = 1'b0;
        ncu_sii_gnt = 1'b0;
        mondo_data  = '0;
        pio_data    = '0;
        step;
        step;
        checkIdleOutputs("reset");
        checkOutput("reset_err", 32'(err_spurious_gnt), 32'd0);

        // Basic mondo transfer right out of reset, fixed payload, 3 req cycles
        rst_l = 1'b1;
        mondo_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0, -1);

        // Lone pio transfer, then two simultaneous requests
        randomizeData();
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, -1);
        randomizeData();
        applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, -1);
        randomizeData();
        applyStimulus(1'b1, 1'b1, 2, 1'b0, 1'b0, -1);

        // Grant pulse while idle
        step;
        ncu_sii_gnt = 1'b1;
        step;
        checkOutput("spur_err", 32'(err_spurious_gnt), 32'd1);
        checkOutput("spur_req", 32'(sii_ncu_req), 32'd0);
        ncu_sii_gnt = 1'b0;
        step;
        checkOutput("spur_err_clr", 32'(err_spurious_gnt), 32'd0);
        checkOutput("spur_req_2", 32'(sii_ncu_req), 32'd0);

        // Parity corner beats
        randomizeData();
        mondo_data[31:0] = 32'h00010000;
        applyStimulus(1'b1, 1'b0, 1, 1'b0, 1'b0, -1);
        randomizeData();
        mondo_data[31:0] = 32'h00000001;
        applyStimulus(1'b1, 1'b0, 1, 1'b0, 1'b0, -1);

        // Grant held across the REQ exit counts once and flags the extra cycle
        randomizeData();
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b1, -1);

        // Back-to-back pio with vld held: second req two cycles after last beat
        randomizeData();
        applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b0, -1);
        randomizeData();
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, -1);

        // Randomized transfers with random idle gaps
        for (int i = 0; i < 10; i++) begin
            bit mv, pv;
            int gap;
            mv = 1'($urandom_range(0, 1));
            pv = 1'($urandom_range(0, 1));
            if (!mv && !pv) pv = 1'b1;
            randomizeData();
            applyStimulus(mv, pv, $urandom_range(1, 4), 1'b0, 1'b0, -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step;
                checkIdleOutputs("gap");
            end
        end

        // Reset during beat 2, then a clean pio transfer after release
        randomizeData();
        applyStimulus(1'b1, 1'b0, 2, 1'b0, 1'b0, 2);
        step;
        checkIdleOutputs("in_reset");
        step;
        rst_l = 1'b1;
        randomizeData();
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
